// File: rtl/proc_fetch_unit.sv
// proc_fetch_unit: credit-limited instruction fetch with a 2-entry response buffer and redirect flush
module proc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_addr,
  input  logic        imemresp_val,
  input  logic [31:0] imemresp_data,
  input  logic        redirect_val,
  input  logic [31:0] redirect_pc,
  output logic        inst_val_D,
  output logic [31:0] inst_D,
  output logic [31:0] pc_D,
  input  logic        inst_rdy_D
);
  logic [31:0] pc_f;
  logic [31:0] pcq [2];
  logic        pcq_wr, pcq_rd;
  logic [31:0] buf_pc [2];
  logic [31:0] buf_inst [2];
  logic        buf_wr, buf_rd;
  logic [1:0]  inflight, occ, drop;
  logic        pop, issue, resp, push;
  assign pop          = inst_val_D & inst_rdy_D;
  assign issue        = imemreq_val & imemreq_rdy;
  // responses with nothing outstanding are protocol violations and are ignored
  assign resp         = imemresp_val & (inflight != 2'd0);
  assign push         = resp & (drop == 2'd0);
  assign imemreq_val  = ~rst & ~redirect_val &
                        (({1'b0, inflight} + {1'b0, occ} - {2'b0, pop}) < 3'(DEPTH));
  assign imemreq_addr = pc_f;
  assign inst_val_D   = occ != 2'd0;
  assign inst_D       = buf_inst[buf_rd];
  assign pc_D         = buf_pc[buf_rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f        <= RESET_PC;
      pcq_wr      <= 1'b0;
      pcq_rd      <= 1'b0;
      buf_wr      <= 1'b0;
      buf_rd      <= 1'b0;
      buf_pc[0]   <= '0;
      buf_pc[1]   <= '0;
      buf_inst[0] <= '0;
      buf_inst[1] <= '0;
      inflight    <= '0;
      occ         <= '0;
      drop        <= '0;
    end else begin
      if (issue) begin
        pcq[pcq_wr] <= pc_f;
        pcq_wr      <= ~pcq_wr;
      end
      if (resp) pcq_rd <= ~pcq_rd;
      if (push) begin
        buf_pc[buf_wr]   <= pcq[pcq_rd];
        buf_inst[buf_wr] <= imemresp_data;
      end
      inflight <= inflight + {1'b0, issue} - {1'b0, resp};
      // every response still outstanding after a redirect cycle is stale
      if (redirect_val) begin
        pc_f   <= redirect_pc;
        occ    <= '0;
        buf_wr <= 1'b0;
        buf_rd <= 1'b0;
        drop   <= inflight - {1'b0, resp};
      end else begin
        if (issue) pc_f <= pc_f + 32'd4;
        occ <= occ + {1'b0, push} - {1'b0, pop};
        if (push) buf_wr <= ~buf_wr;
        if (pop) buf_rd <= ~buf_rd;
        if (resp && drop != 2'd0) drop <= drop - 2'd1;
      end
    end
  end
endmodule
